// File: rtl/issue_pkg.sv
// Shared widths and bundles for the issue reservation station.
package issue_pkg;
  localparam int RS_XLEN      = 32;
  localparam int ROB_SIZE     = 6;
  localparam int ALU_OP_WIDTH = 5;
  localparam int THREAD_WIDTH = 2;

  typedef struct packed {
    logic                    valid;
    logic [THREAD_WIDTH-1:0] thread;
    logic [ALU_OP_WIDTH-1:0] op;
    logic [ROB_SIZE-1:0]     rob_tag;
    logic                    rs1_rdy;
    logic [ROB_SIZE-1:0]     rs1_q;
    logic [RS_XLEN-1:0]      rs1_val;
    logic                    rs2_rdy;
    logic [ROB_SIZE-1:0]     rs2_q;
    logic [RS_XLEN-1:0]      rs2_val;
  } rs_entry_t;

  typedef struct packed {
    logic                valid;
    logic [ROB_SIZE-1:0] tag;
    logic [RS_XLEN-1:0]  value;
  } cdb_bus_t;
endpackage

// File: rtl/rs_age_matrix.sv
// Older-than matrix; grants the oldest requesting entry.
module rs_age_matrix #(
  parameter int ENTRIES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ENTRIES-1:0] alloc_onehot,
  input  logic [ENTRIES-1:0] free_mask,
  input  logic [ENTRIES-1:0] req_mask,
  output logic [ENTRIES-1:0] grant_onehot
);
  // older_q[i][j] set means entry i was allocated before entry j
  logic [ENTRIES-1:0] older_q [ENTRIES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++)
        older_q[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++)
        for (int j = 0; j < ENTRIES; j++)
          if (i == j)
            older_q[i][j] <= 1'b0;
          else if (alloc_onehot[j])
            older_q[i][j] <= 1'b1;
          else if (alloc_onehot[i])
            older_q[i][j] <= 1'b0;
          else if (free_mask[i] || free_mask[j])
            older_q[i][j] <= 1'b0;
    end
  end

  always_comb begin
    grant_onehot = req_mask;
    for (int i = 0; i < ENTRIES; i++)
      for (int j = 0; j < ENTRIES; j++)
        if (i != j && req_mask[j] && older_q[j][i])
          grant_onehot[i] = 1'b0;
  end
endmodule

// File: rtl/issue_rs_queue.sv
// Multi-entry reservation station with CDB snooping,
// oldest-ready select and a registered valid/ready output.
module issue_rs_queue
  import issue_pkg::*;
#(
  parameter int XLEN     = RS_XLEN,
  parameter int TAG_W    = ROB_SIZE,
  parameter int OP_W     = ALU_OP_WIDTH,
  parameter int ENTRIES  = 4,
  parameter int NUM_CDB  = 2,
  parameter int THREAD_W = THREAD_WIDTH,
  parameter int CNT_W    = $clog2(ENTRIES+1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_i,
  input  logic                    flush_i,
  input  logic [THREAD_W-1:0]     flush_thread_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [OP_W-1:0]         in_op_i,
  input  logic [THREAD_W-1:0]     in_thread_i,
  input  logic [TAG_W-1:0]        in_rob_tag_i,
  input  logic                    in_rs1_rdy_i,
  input  logic [XLEN-1:0]         in_rs1_val_i,
  input  logic [TAG_W-1:0]        in_rs1_q_i,
  input  logic                    in_rs2_rdy_i,
  input  logic [XLEN-1:0]         in_rs2_val_i,
  input  logic [TAG_W-1:0]        in_rs2_q_i,
  input  logic [NUM_CDB-1:0]      cdb_valid_i,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag_i,
  input  logic [NUM_CDB*XLEN-1:0] cdb_value_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [OP_W-1:0]         out_op_o,
  output logic [THREAD_W-1:0]     out_thread_o,
  output logic [TAG_W-1:0]        out_rob_tag_o,
  output logic [XLEN-1:0]         out_rs1_o,
  output logic [XLEN-1:0]         out_rs2_o,
  output logic [CNT_W-1:0]        count_o
);
  localparam int IDX_W = $clog2(ENTRIES);

  rs_entry_t          ent_q [ENTRIES];
  cdb_bus_t           cdb [NUM_CDB];
  rs_entry_t          new_ent, pick;
  logic [ENTRIES-1:0] valid_vec, req_mask, grant, alloc_oh;
  logic [ENTRIES-1:0] free_mask, flush_hit, w1_hit, w2_hit;
  logic [XLEN-1:0]    w1_val [ENTRIES];
  logic [XLEN-1:0]    w2_val [ENTRIES];
  logic [XLEN-1:0]    b1_val, b2_val;
  logic               b1_hit, b2_hit;
  logic [IDX_W-1:0]   free_idx;
  logic               alloc_fire, load;

  always_comb begin
    for (int k = 0; k < NUM_CDB; k++) begin
      cdb[k].valid = cdb_valid_i[k];
      cdb[k].tag   = cdb_tag_i[k*TAG_W +: TAG_W];
      cdb[k].value = cdb_value_i[k*XLEN +: XLEN];
    end
  end

  // Scan high to low so the lowest matching bus wins
  function automatic logic snoop(input logic [TAG_W-1:0] q,
                                 output logic [XLEN-1:0] v);
    snoop = 1'b0;
    v = '0;
    for (int k = NUM_CDB-1; k >= 0; k--)
      if (cdb[k].valid && cdb[k].tag == q) begin
        snoop = 1'b1;
        v = cdb[k].value;
      end
  endfunction

  always_comb begin
    count_o  = '0;
    free_idx = '0;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      valid_vec[i] = ent_q[i].valid;
      flush_hit[i] = flush_i && ent_q[i].valid &&
                     ent_q[i].thread == flush_thread_i;
      req_mask[i]  = ent_q[i].valid && ent_q[i].rs1_rdy &&
                     ent_q[i].rs2_rdy && !flush_hit[i];
      w1_hit[i] = snoop(ent_q[i].rs1_q, w1_val[i]) &&
                  ent_q[i].valid && !ent_q[i].rs1_rdy;
      w2_hit[i] = snoop(ent_q[i].rs2_q, w2_val[i]) &&
                  ent_q[i].valid && !ent_q[i].rs2_rdy;
      count_o = count_o + CNT_W'(ent_q[i].valid);
      if (!ent_q[i].valid)
        free_idx = IDX_W'(i);
    end
  end

  assign in_ready_o = (count_o < CNT_W'(ENTRIES)) && !stall_i;
  assign alloc_fire = in_valid_i && in_ready_o &&
                      !(flush_i && in_thread_i == flush_thread_i);
  assign alloc_oh   = alloc_fire ? (ENTRIES'(1) << free_idx) : '0;
  assign load       = (!out_valid_o || out_ready_i) && !stall_i &&
                      (|req_mask);
  assign free_mask  = (load ? grant : '0) | flush_hit;

  always_comb begin
    b1_hit = snoop(in_rs1_q_i, b1_val);
    b2_hit = snoop(in_rs2_q_i, b2_val);
    new_ent.valid   = 1'b1;
    new_ent.thread  = in_thread_i;
    new_ent.op      = in_op_i;
    new_ent.rob_tag = in_rob_tag_i;
    new_ent.rs1_q   = in_rs1_q_i;
    new_ent.rs2_q   = in_rs2_q_i;
    new_ent.rs1_rdy = in_rs1_rdy_i || b1_hit;
    new_ent.rs2_rdy = in_rs2_rdy_i || b2_hit;
    new_ent.rs1_val = in_rs1_rdy_i ? in_rs1_val_i : b1_val;
    new_ent.rs2_val = in_rs2_rdy_i ? in_rs2_val_i : b2_val;
  end

  always_comb begin
    pick = '0;
    for (int i = 0; i < ENTRIES; i++)
      if (grant[i])
        pick = ent_q[i];
  end

  rs_age_matrix #(.ENTRIES(ENTRIES)) u_age (
    .clk          (clk),
    .rst          (rst),
    .alloc_onehot (alloc_oh),
    .free_mask    (free_mask),
    .req_mask     (req_mask),
    .grant_onehot (grant)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++)
        ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (alloc_oh[i]) begin
          ent_q[i] <= new_ent;
        end else begin
          if (free_mask[i])
            ent_q[i].valid <= 1'b0;
          if (w1_hit[i]) begin
            ent_q[i].rs1_rdy <= 1'b1;
            ent_q[i].rs1_val <= w1_val[i];
          end
          if (w2_hit[i]) begin
            ent_q[i].rs2_rdy <= 1'b1;
            ent_q[i].rs2_val <= w2_val[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_o   <= 1'b0;
      out_op_o      <= '0;
      out_thread_o  <= '0;
      out_rob_tag_o <= '0;
      out_rs1_o     <= '0;
      out_rs2_o     <= '0;
    end else if (load) begin
      out_valid_o   <= 1'b1;
      out_op_o      <= pick.op;
      out_thread_o  <= pick.thread;
      out_rob_tag_o <= pick.rob_tag;
      out_rs1_o     <= pick.rs1_val;
      out_rs2_o     <= pick.rs2_val;
    end else if (flush_i && out_valid_o &&
                 out_thread_o == flush_thread_i) begin
      out_valid_o   <= 1'b0;
      out_op_o      <= '0;
      out_thread_o  <= '0;
      out_rob_tag_o <= '0;
      out_rs1_o     <= '0;
      out_rs2_o     <= '0;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end
endmodule
